bram_sdp_window: RTL and testbench
==================================

# bram_sdp_window

Single-clock simple dual-port block RAM with a parametrised multi-word read window: one write port stores one WIDTH-bit word per cycle, and the read port returns LANES consecutive words starting at any address. Reads pass through an optional output pipeline stage with a valid/ready handshake, so the block can feed stalling consumers directly. It serves as the read-window buffer for line and sprite fetch paths, and is the generalised successor of the fixed four-word read RAM.

## Interface
- WIDTH, 8, bits per stored word
- DEPTH, 256, words in memory; ADDRW = $clog2(DEPTH) (localparam)
- LANES, 4, words returned per read (1..DEPTH)
- OUT_REG, 0, 0: read latency 1; 1: extra output register, latency 2
- WRAP, 1, 1: window addresses wrap modulo DEPTH; 0: lanes past DEPTH-1 read as zero and are masked
- INIT_F, "", hex init file loaded with $readmemh when non-empty
- clk  in  1  single clock for all ports
- rst_n  in  1  reset: asynchronous, active-low (clears pipeline state only, never memory contents)
- we  in  1  write enable
- addr_write  in  ADDRW  write address
- data_in  in  WIDTH  write data
- rd_req  in  1  read request; accepted on a cycle with rd_req && rd_ack
- rd_ack  out  1  read pipeline can accept a request this cycle
- addr_read  in  ADDRW  base address of the window, sampled on acceptance
- data_out  out  LANES*WIDTH  lane i in bits [i*WIDTH +: WIDTH] = word at base+i
- lane_mask  out  LANES  bit i set = lane i is a real memory word
- data_valid  out  1  data_out and lane_mask are valid
- data_ready  in  1  consumer accepts data when data_valid && data_ready

## Operation
- Write: on posedge clk with we, memory[addr_write] <= data_in. Writes are never blocked by the read-side state.
- Lane address: base+i is computed in ADDRW+1 bits. WRAP=1: use the value modulo DEPTH, and all mask bits are 1. WRAP=0: if base+i > DEPTH-1, the lane is 0 and its mask bit is 0.
- Read-during-write: if an accepted read and a write hit the same word in one cycle, the read returns the old contents. The new value is visible to reads accepted from the next cycle.
- Pipeline, OUT_REG=0: a single stage S1 (valid bit v1) drives the outputs directly; data_valid = v1.
- Pipeline, OUT_REG=1: stage S1 (v1) feeds an output stage S2 (v2); data_valid = v2.
- Advance rules, OUT_REG=0: rd_ack = !v1 || data_ready.
- Advance rules, OUT_REG=1: S2 loads when v1 && (!v2 || data_ready); rd_ack = !v1 || S2 loads this cycle.
- Stall: a stage whose valid bit is set and that cannot advance holds its data and mask unchanged. The output does not change while data_valid && !data_ready.
- A stage's valid bit clears when its data leaves and no new data enters.
- rd_req while !rd_ack is ignored, not queued; the requester must hold it.
- Addresses outside 0..DEPTH-1 (non-power-of-two DEPTH) are undefined for writes; for reads they follow the WRAP/mask rule on the ADDRW+1-bit sum.

## Timing
- Reset (rst_n low, asynchronous): v1, v2, data_valid, data_out and lane_mask are all 0. rd_ack is 1 from the first cycle after release. Memory keeps its contents.
- Reset mid-operation: in-flight reads are discarded. No data_valid pulse follows release without a new request.
- Latency: request accepted at edge N gives data_valid at edge N+1 (OUT_REG=0) or N+2 (OUT_REG=1), provided the output is not stalled.
- Throughput: one window per cycle while data_ready is held high.
- Bubble-free: with OUT_REG=1, S1 refills in the same cycle S2 drains.

## Test plan
- Reset, then write words 0x10..0x1F to addresses 0..15. Read base 3, LANES=4 -> data_out = {0x16,0x15,0x14,0x13}, lane_mask = 4'b1111, data_valid one cycle after acceptance (OUT_REG=0).
- DEPTH=16, WRAP=1, read base 14 -> lanes = words 14,15,0,1. Same read with WRAP=0 -> lanes 2,3 = 0 and lane_mask = 4'b0011.
- Same cycle: write 0xAA to address 5 and accept a read at base 4 -> lane1 returns the old word. A read at base 4 on the next cycle returns 0xAA in lane1.
- OUT_REG=1, rd_req held high, data_ready low for 3 cycles -> data_out is stable and rd_ack drops once both stages are full. Raise data_ready -> windows come out in order with none lost or duplicated, one per cycle.
- Pull rst_n low with two reads in flight -> data_valid, data_out and lane_mask go to 0 immediately, with no valid after release. A subsequent read still returns the pre-reset memory contents.
- Random stimulus (we, rd_req, data_ready toggling, both OUT_REG values) against a reference model -> every accepted request is delivered exactly once, in order, with correct lanes and mask.

Source files
------------

// File: rtl/bram_sdp_window.sv
// bram_sdp_window
//
// Single-clock simple dual-port RAM whose read port returns a window of LANES
// consecutive words starting at any base address. Reads go through one (S1)
// or two (S1 + S2) pipeline stages with a valid/ready handshake, so the block
// can drive a stalling consumer directly.
//
// Ports
//   clk         single clock for both ports
//   rst_n       asynchronous active-low reset; clears the read pipeline only,
//               never the memory contents
//   we          write enable
//   addr_write  write address
//   data_in     write data
//   rd_req      read request, accepted when rd_req && rd_ack
//   rd_ack      read pipeline can take a request this cycle
//   addr_read   window base address, sampled on acceptance
//   data_out    lane i in bits [i*WIDTH +: WIDTH] = word at base+i
//   lane_mask   bit i set = lane i holds a real memory word
//   data_valid  data_out / lane_mask are valid
//   data_ready  consumer takes the window when data_valid && data_ready

module bram_sdp_window #(
    parameter int    WIDTH   = 8,
    parameter int    DEPTH   = 256,
    parameter int    LANES   = 4,
    parameter int    OUT_REG = 0,
    parameter int    WRAP    = 1,
    parameter string INIT_F  = "",
    localparam int   ADDRW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [ADDRW-1:0]       addr_write,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   rd_req,
    output logic                   rd_ack,
    input  logic [ADDRW-1:0]       addr_read,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       lane_mask,
    output logic                   data_valid,
    input  logic                   data_ready
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr_write] <= data_in;
        end
    end

    // Window gather. S1 samples mem_q on the same edge a write lands, so a
    // read and write to the same word in one cycle returns the old word.
    logic [LANES*WIDTH-1:0] win_d;
    logic [LANES-1:0]       wmask_d;
    logic [ADDRW:0]         lane_sum;
    logic [ADDRW-1:0]       lane_idx;

    always_comb begin
        win_d    = '0;
        wmask_d  = '0;
        lane_sum = '0;
        lane_idx = '0;
        for (int i = 0; i < LANES; i++) begin
            // One extra bit so the overflow past DEPTH-1 is visible.
            lane_sum = {1'b0, addr_read} + (ADDRW+1)'(i);
            if (WRAP != 0) begin
                lane_idx = ADDRW'(lane_sum % (ADDRW+1)'(DEPTH));
                win_d[i*WIDTH +: WIDTH] = mem_q[lane_idx];
                wmask_d[i] = 1'b1;
            end else if (lane_sum <= (ADDRW+1)'(DEPTH-1)) begin
                win_d[i*WIDTH +: WIDTH] = mem_q[lane_sum[ADDRW-1:0]];
                wmask_d[i] = 1'b1;
            end
        end
    end

    // Stage S1
    logic                   v1_q, v1_d;
    logic [LANES*WIDTH-1:0] d1_q;
    logic [LANES-1:0]       m1_q;
    logic                   accept;
    logic                   s1_free;    // S1 contents leave at this edge

    assign rd_ack = !v1_q || s1_free;
    assign accept = rd_req && rd_ack;
    assign v1_d   = accept ? 1'b1 : (s1_free ? 1'b0 : v1_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            d1_q <= '0;
            m1_q <= '0;
        end else begin
            v1_q <= v1_d;
            if (accept) begin
                d1_q <= win_d;
                m1_q <= wmask_d;
            end
        end
    end

    generate
        if (OUT_REG == 0) begin : g_direct
            assign s1_free    = data_ready;
            assign data_valid = v1_q;
            assign data_out   = d1_q;
            assign lane_mask  = m1_q;
        end else begin : g_outreg
            logic                   v2_q, v2_d;
            logic [LANES*WIDTH-1:0] d2_q;
            logic [LANES-1:0]       m2_q;
            logic                   s2_load;

            // S2 refills in the same cycle it drains, so no bubble is inserted.
            assign s2_load = v1_q && (!v2_q || data_ready);
            assign s1_free = s2_load;
            assign v2_d    = s2_load ? 1'b1 : (data_ready ? 1'b0 : v2_q);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v2_q <= 1'b0;
                    d2_q <= '0;
                    m2_q <= '0;
                end else begin
                    v2_q <= v2_d;
                    if (s2_load) begin
                        d2_q <= d1_q;
                        m2_q <= m1_q;
                    end
                end
            end

            assign data_valid = v2_q;
            assign data_out   = d2_q;
            assign lane_mask  = m2_q;
        end
    endgenerate

endmodule

// File: tb/tb_bram_sdp_window.sv
// Testbench for bram_sdp_window. Two instances share the stimulus:
//   inst 0: DEPTH=16, LANES=4, OUT_REG=0, WRAP=1
//   inst 1: DEPTH=16, LANES=4, OUT_REG=1, WRAP=0
// Each has a queue of expected windows filled from an array model of memory.

module tb_bram_sdp_window;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  mask;
        int          acc;   // edge number at which the request was accepted
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        we = 1'b0;
    logic        rd_req = 1'b0;
    logic        data_ready = 1'b0;
    logic [3:0]  addr_write = '0;
    logic [3:0]  addr_read = '0;
    logic [7:0]  data_in = '0;

    logic        ack [2];
    logic        dv [2];
    logic [31:0] dout [2];
    logic [3:0]  mask [2];

    logic [7:0]  mdl [16];
    item_t       sb [2][$];

    int total = 0;
    int bad = 0;
    int edges = 0;

    always #5 clk = ~clk;

    bram_sdp_window #(.WIDTH(8), .DEPTH(16), .LANES(4), .OUT_REG(0), .WRAP(1), .INIT_F("")) u_a (
        .clk(clk), .rst_n(rst_n), .we(we), .addr_write(addr_write), .data_in(data_in),
        .rd_req(rd_req), .rd_ack(ack[0]), .addr_read(addr_read), .data_out(dout[0]),
        .lane_mask(mask[0]), .data_valid(dv[0]), .data_ready(data_ready));

    bram_sdp_window #(.WIDTH(8), .DEPTH(16), .LANES(4), .OUT_REG(1), .WRAP(0), .INIT_F("")) u_b (
        .clk(clk), .rst_n(rst_n), .we(we), .addr_write(addr_write), .data_in(data_in),
        .rd_req(rd_req), .rd_ack(ack[1]), .addr_read(addr_read), .data_out(dout[1]),
        .lane_mask(mask[1]), .data_valid(dv[1]), .data_ready(data_ready));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic item_t model_win(input int base, input int wrap);
        item_t it;
        it.data = '0;
        it.mask = '0;
        it.acc  = 0;
        for (int i = 0; i < 4; i++) begin
            int s;
            s = base + i;
            if (wrap != 0) begin
                it.data[i*8 +: 8] = mdl[s % 16];
                it.mask[i] = 1'b1;
            end else if (s < 16) begin
                it.data[i*8 +: 8] = mdl[s];
                it.mask[i] = 1'b1;
            end
        end
        return it;
    endfunction

    // Inputs are set at the falling edge before calling; this checks the
    // handshake outputs, updates the model, and advances one clock.
    task automatic step();
        item_t it;
        int    n;
        logic  eack;
        logic  edv;
        #1;
        for (int k = 0; k < 2; k++) begin
            n = sb[k].size();
            // Pipeline holds k+1 windows; it takes a new one if not full or if draining.
            eack = (n < k + 1) || data_ready;
            chk($sformatf("rd_ack%0d", k), 64'(ack[k]), 64'(eack));
            edv = 1'b0;
            if (n > 0) edv = (edges >= sb[k][0].acc + k);
            chk($sformatf("data_valid%0d", k), 64'(dv[k]), 64'(edv));
            if (edv) begin
                chk($sformatf("data_out%0d", k), 64'(dout[k]), 64'(sb[k][0].data));
                chk($sformatf("lane_mask%0d", k), 64'(mask[k]), 64'(sb[k][0].mask));
                if (data_ready) void'(sb[k].pop_front());
            end
            if (rd_req && eack) begin
                it = model_win(int'(addr_read), 1 - k);
                it.acc = edges + 1;
                sb[k].push_back(it);
            end
        end
        if (we) mdl[addr_write] = data_in;
        @(posedge clk);
        edges++;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_valid%0d", k), 64'(dv[k]), 64'(0));
            chk($sformatf("rst_data%0d", k), 64'(dout[k]), 64'(0));
            chk($sformatf("rst_mask%0d", k), 64'(mask[k]), 64'(0));
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        data_ready = 1'b1;

        // Fill memory with 0x10..0x1F
        for (int i = 0; i < 16; i++) begin
            we = 1'b1;
            addr_write = 4'(i);
            data_in = 8'(8'h10 + i);
            step();
        end
        we = 1'b0;

        // Plain window at base 3
        rd_req = 1'b1;
        addr_read = 4'd3;
        step();
        rd_req = 1'b0;
        chk("b3_valid0", 64'(dv[0]), 64'(1));
        chk("b3_data0", 64'(dout[0]), 64'(32'h16151413));
        chk("b3_mask0", 64'(mask[0]), 64'(4'hF));
        step();
        chk("b3_valid1", 64'(dv[1]), 64'(1));
        chk("b3_data1", 64'(dout[1]), 64'(32'h16151413));
        step();

        // Window crossing the top of memory: wrap vs mask
        rd_req = 1'b1;
        addr_read = 4'd14;
        step();
        rd_req = 1'b0;
        chk("b14_wrap_data", 64'(dout[0]), 64'(32'h11101F1E));
        chk("b14_wrap_mask", 64'(mask[0]), 64'(4'hF));
        step();
        chk("b14_nowrap_data", 64'(dout[1]), 64'(32'h00001F1E));
        chk("b14_nowrap_mask", 64'(mask[1]), 64'(4'b0011));
        step();

        // Read-during-write returns old data, new data next cycle
        we = 1'b1;
        addr_write = 4'd5;
        data_in = 8'hAA;
        rd_req = 1'b1;
        addr_read = 4'd4;
        step();
        we = 1'b0;
        chk("rdw_old", 64'(dout[0]), 64'(32'h17161514));
        step();
        chk("rdw_new", 64'(dout[0]), 64'(32'h1716AA14));
        rd_req = 1'b0;
        step();
        step();

        // Stall with OUT_REG=1: both stages fill, then drain in order
        data_ready = 1'b0;
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr_read = 4'(i + 7);
            step();
        end
        chk("stall_ack1", 64'(ack[1]), 64'(0));
        chk("stall_valid1", 64'(dv[1]), 64'(1));
        data_ready = 1'b1;
        step();
        rd_req = 1'b0;
        repeat (4) step();

        // Reset with reads in flight
        data_ready = 1'b0;
        rd_req = 1'b1;
        addr_read = 4'd2;
        step();
        addr_read = 4'd9;
        step();
        rd_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("midrst_valid%0d", k), 64'(dv[k]), 64'(0));
            chk($sformatf("midrst_data%0d", k), 64'(dout[k]), 64'(0));
            chk($sformatf("midrst_mask%0d", k), 64'(mask[k]), 64'(0));
            sb[k].delete();
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        data_ready = 1'b1;
        repeat (3) step();
        rd_req = 1'b1;
        addr_read = 4'd0;
        step();
        rd_req = 1'b0;
        chk("postrst_data0", 64'(dout[0]), 64'(32'h13121110));
        repeat (2) step();

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            we = 1'($urandom_range(0, 1));
            addr_write = 4'($urandom_range(0, 15));
            data_in = 8'($urandom);
            rd_req = ($urandom_range(0, 3) != 0);
            addr_read = 4'($urandom_range(0, 15));
            data_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        we = 1'b0;
        rd_req = 1'b0;
        data_ready = 1'b1;
        repeat (4) step();
        chk("drained0", 64'(sb[0].size()), 64'(0));
        chk("drained1", 64'(sb[1].size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
